answer_judge: RTL and testbench
===============================

// Module: answer_judge
// PURPOSE
//   Response side of the quiz question path: takes the 3-digit BCD target number issued to the player
//   and the player's entered factors (6 BCD digits = three 2-digit factors A,B,C).
//   Computes A*B*C with a serial shift-add multiplier and judges OK/NG.
//   Sits between the answer-entry block (digit registers) and the game control FSM (consumes VALID/OK/NG).
// PARAMETERS
//   FACT_W  7   binary width of one factor (2-digit BCD 0..99)
//   PROD_W  21  product width (>= 3*FACT_W; 99^3 = 970299 fits)
// PORTS
//   CLK       in   1   system clock, all state on rising edge
//   RST       in   1   reset, asynchronous, active-high
//   START     in   1   1-cycle request to judge; sampled only in IDLE
//   QUESTION  in   12  target, BCD {hundreds,tens,units}, 0..999
//   ANSWER    in   24  BCD {A_tens,A_units,B_tens,B_units,C_tens,C_units}
//   BUSY      out  1   high from cycle after accepted START until VALID cycle inclusive
//   VALID     out  1   1-cycle pulse: OK/NG/PRODUCT/BCD_ERR updated this cycle
//   OK        out  1   held verdict: answer correct
//   NG        out  1   held verdict: answer wrong (OK and NG never both high)
//   BCD_ERR   out  1   held: some input nibble > 9 in the last judged request
//   PRODUCT   out  21  held A*B*C (zero factors mapped to 1), for display/debug
// BEHAVIOUR
//   Reset: FSM=IDLE; BUSY, VALID, OK, NG, BCD_ERR = 0; PRODUCT = 0; datapath regs cleared.
//   FSM: IDLE -> LOAD -> MUL1 -> MUL2 -> CMP -> IDLE.
//   IDLE: START=1 latches QUESTION and ANSWER into regs, goes to LOAD. START=0 stays.
//   LOAD (1 cycle):
//     - BCD->binary: Q = 100h+10t+u; A,B,C = 10t+u.
//     - A factor of 0 is "unused" and is replaced by 1.
//     - Any nibble > 9 sets the internal error flag.
//   MUL1 (FACT_W cycles): P = A*B, shift-add, one multiplier bit per cycle, LSB first.
//   MUL2 (FACT_W cycles): P = P*C, same scheme. Accumulator is PROD_W wide; no overflow possible.
//   CMP (1 cycle): match = (P == zero-extended Q).
//   Verdict is forced to NG when any of these hold:
//     - error flag set;
//     - all three raw factors are 0;
//     - Q = 0.
//   Next edge: VALID=1 for one cycle; OK/NG/BCD_ERR/PRODUCT loaded and held until next VALID.
//   Latency: START at edge 0 -> VALID high in cycle 3+2*FACT_W (17 at default); fixed, data-independent.
//   Errors do not shorten the run.
//   START while BUSY: ignored, no queueing. START in the VALID cycle: ignored.
//     - Earliest re-accept is the cycle after VALID.
//   QUESTION/ANSWER changes after START acceptance have no effect on the running judgment.
//   Previous OK/NG stay visible while BUSY; they are cleared only by reset or replaced at VALID.
//   Reset mid-operation: immediate return to IDLE, all outputs 0, no VALID emitted.
// CONFIGURATION
//   JUDGE_PRIME_CHECK_EN
//     defined:
//       - in LOAD, each nonzero raw factor is looked up in a 0..99 prime table (25 entries);
//       - any non-prime nonzero factor forces NG even if the product matches;
//       - latency unchanged.
//     undefined: no prime table synthesized; verdict depends on product match and error rules only.
// TESTING
//   1. Q=012, ANS=02_02_03, START -> VALID at cycle 17, OK=1, NG=0, PRODUCT=12, BUSY high cycles 1..17.
//   2. Q=012, ANS=02_07_00 -> VALID, NG=1, OK=0, PRODUCT=14. Then ANS=04_03_00 -> OK=1, PRODUCT=12
//      (prime check off). Same with JUDGE_PRIME_CHECK_EN -> NG=1, PRODUCT=12.
//   3. Q=999, ANS=00_00_00 -> NG=1, PRODUCT=1. Q=970, ANS=99_99_99 -> NG=1, PRODUCT=970299 (no overflow).
//   4. Q=012, ANS=0A_03_04 (nibble 0xA) -> VALID at cycle 17, NG=1, BCD_ERR=1.
//   5. START at cycle 0, second START at cycle 5 with other operands -> single VALID at 17,
//      result from first operands. START at cycle 18 is accepted.
//   6. RST pulsed at cycle 8 of a run -> all outputs 0 asynchronously, no VALID.
//      New START afterwards judges normally with 17-cycle latency.

Source files
------------

// File: rtl/answer_judge.sv
// ---------------------------------------------------------------------------
// answer_judge
//   Judges a quiz answer. The target is a 3-digit BCD number, and the answer
//   is three 2-digit BCD factors A, B and C. The block converts everything to
//   binary and forms A*B*C with a serial shift-add multiplier that handles one
//   multiplier bit per cycle. It then compares the product with the target
//   and reports OK or NG.
//   Latency is fixed at 3+2*FACT_W cycles from the accepting edge to VALID.
//
// Optional feature macro: JUDGE_PRIME_CHECK_EN
//   When it is defined, every nonzero raw factor must be prime. A factor that
//   is not prime forces NG, even when the product matches.
//
// Ports
//   CLK       in   clock; all state changes on the rising edge
//   RST       in   asynchronous reset, active high
//   START     in   1-cycle judge request; accepted only when idle and not VALID
//   QUESTION  in   [11:0]  BCD target {hundreds,tens,units}
//   ANSWER    in   [23:0]  BCD {A_t,A_u,B_t,B_u,C_t,C_u}
//   BUSY      out  high from the cycle after acceptance through the VALID cycle
//   VALID     out  1-cycle pulse; the held outputs below update in this cycle
//   OK / NG   out  held verdict; the two are never high together
//   BCD_ERR   out  held; some nibble of the judged request was > 9
//   PRODUCT   out  [PROD_W-1:0] held A*B*C, with zero factors mapped to 1
// ---------------------------------------------------------------------------
module answer_judge #(
   parameter int FACT_W = 7,
   parameter int PROD_W = 21
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [11:0]       QUESTION,
   input  logic [23:0]       ANSWER,
   output logic              BUSY,
   output logic              VALID,
   output logic              OK,
   output logic              NG,
   output logic              BCD_ERR,
   output logic [PROD_W-1:0] PRODUCT
);

   localparam int CNT_W = (FACT_W > 1) ? $clog2(FACT_W) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL1, S_MUL2, S_CMP} state_t;

   // Two-digit BCD to binary. An out-of-range nibble still yields some value.
   // That value only reaches PRODUCT, because such a request is forced to NG.
   function automatic logic [FACT_W-1:0] bcd2bin(input logic [7:0] d);
      logic [7:0] v;
      v = (8'(d[7:4]) * 8'd10) + 8'(d[3:0]);
      return FACT_W'(v);
   endfunction

   state_t              r_state, w_state_nxt;
   logic [11:0]         r_q_bcd;
   logic [23:0]         r_ans_bcd;
   logic [11:0]         r_q_bin;
   logic [FACT_W-1:0]   r_c;
   logic                r_err;
   logic                r_all_zero;
   logic [PROD_W-1:0]   r_acc;
   logic [PROD_W-1:0]   r_mcand;
   logic [FACT_W-1:0]   r_mplier;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_valid, r_ok, r_ng, r_bcd_err;
   logic [PROD_W-1:0]   r_product;

   logic                w_accept, w_last, w_nib_err, w_prime_fail, w_ok;
   logic [FACT_W-1:0]   w_a_raw, w_b_raw, w_c_raw;
   logic [11:0]         w_q_bin;
   logic [PROD_W-1:0]   w_acc_nxt;

   // Conversion of the latched request. It is used only in LOAD.
   assign w_a_raw = bcd2bin(r_ans_bcd[23:16]);
   assign w_b_raw = bcd2bin(r_ans_bcd[15:8]);
   assign w_c_raw = bcd2bin(r_ans_bcd[7:0]);
   assign w_q_bin = (12'(r_q_bcd[11:8]) * 12'd100) + (12'(r_q_bcd[7:4]) * 12'd10)
                  + 12'(r_q_bcd[3:0]);

   always_comb begin
      w_nib_err = 1'b0;
      for (int i = 0; i < 6; i++)
         if (r_ans_bcd[i*4 +: 4] > 4'd9) w_nib_err = 1'b1;
      for (int i = 0; i < 3; i++)
         if (r_q_bcd[i*4 +: 4] > 4'd9) w_nib_err = 1'b1;
   end

   // One shift-add step. Both multiply phases share it.
   assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_last    = (r_cnt == CNT_W'(FACT_W - 1));

`ifdef JUDGE_PRIME_CHECK_EN
   logic r_prime_bad;

   function automatic logic is_prime(input logic [FACT_W-1:0] v);
      case (7'(v))
         7'd2,  7'd3,  7'd5,  7'd7,  7'd11, 7'd13, 7'd17, 7'd19, 7'd23,
         7'd29, 7'd31, 7'd37, 7'd41, 7'd43, 7'd47, 7'd53, 7'd59, 7'd61,
         7'd67, 7'd71, 7'd73, 7'd79, 7'd83, 7'd89, 7'd97: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         r_prime_bad <= 1'b0;
      else if (r_state == S_LOAD)
         r_prime_bad <= ((w_a_raw != '0) && !is_prime(w_a_raw))
                     || ((w_b_raw != '0) && !is_prime(w_b_raw))
                     || ((w_c_raw != '0) && !is_prime(w_c_raw));
   end

   assign w_prime_fail = r_prime_bad;
`else
   assign w_prime_fail = 1'b0;
`endif

   // The verdict is formed in CMP and registered on the edge that raises VALID.
   assign w_ok = (r_acc == PROD_W'(r_q_bin)) && !r_err && !r_all_zero
              && (r_q_bin != 12'd0) && !w_prime_fail;

   // ---- FSM: state register ----
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // ---- FSM: next state ----
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_MUL1;
         S_MUL1:  if (w_last) w_state_nxt = S_MUL2;
         S_MUL2:  if (w_last) w_state_nxt = S_CMP;
         S_CMP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   // The VALID cycle is spent in IDLE. r_valid blocks acceptance in that cycle
   // and keeps BUSY high through it.
   always_comb begin
      w_accept = (r_state == S_IDLE) && START && !r_valid;
      BUSY     = (r_state != S_IDLE) || r_valid;
      VALID    = r_valid;
      OK       = r_ok;
      NG       = r_ng;
      BCD_ERR  = r_bcd_err;
      PRODUCT  = r_product;
   end

   // ---- datapath ----
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_q_bcd    <= '0;
         r_ans_bcd  <= '0;
         r_q_bin    <= '0;
         r_c        <= '0;
         r_err      <= 1'b0;
         r_all_zero <= 1'b0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_cnt      <= '0;
         r_valid    <= 1'b0;
         r_ok       <= 1'b0;
         r_ng       <= 1'b0;
         r_bcd_err  <= 1'b0;
         r_product  <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_q_bcd   <= QUESTION;
                  r_ans_bcd <= ANSWER;
               end
            end
            S_LOAD: begin
               // An unused (zero) factor acts as 1 so that it drops out of the product.
               r_mcand    <= PROD_W'((w_a_raw == '0) ? FACT_W'(1) : w_a_raw);
               r_mplier   <= (w_b_raw == '0) ? FACT_W'(1) : w_b_raw;
               r_c        <= (w_c_raw == '0) ? FACT_W'(1) : w_c_raw;
               r_q_bin    <= w_q_bin;
               r_err      <= w_nib_err;
               r_all_zero <= (w_a_raw == '0) && (w_b_raw == '0) && (w_c_raw == '0);
               r_acc      <= '0;
               r_cnt      <= '0;
            end
            S_MUL1, S_MUL2: begin
               if (w_last) begin
                  r_cnt <= '0;
                  if (r_state == S_MUL1) begin
                     // A*B becomes the multiplicand of the second pass.
                     r_mcand  <= w_acc_nxt;
                     r_acc    <= '0;
                     r_mplier <= r_c;
                  end else begin
                     r_acc <= w_acc_nxt;
                  end
               end else begin
                  r_cnt    <= r_cnt + CNT_W'(1);
                  r_acc    <= w_acc_nxt;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
               end
            end
            S_CMP: begin
               r_valid   <= 1'b1;
               r_product <= r_acc;
               r_ok      <= w_ok;
               r_ng      <= !w_ok;
               r_bcd_err <= r_err;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_answer_judge.sv
module tb_answer_judge;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic [11:0] QUESTION = '0;
   logic [23:0] ANSWER = '0;
   logic        BUSY, VALID, OK, NG, BCD_ERR;
   logic [20:0] PRODUCT;

   int checks = 0;
   int errors = 0;

   answer_judge #(.FACT_W(7), .PROD_W(21)) dut (
      .CLK(CLK), .RST(RST), .START(START), .QUESTION(QUESTION), .ANSWER(ANSWER),
      .BUSY(BUSY), .VALID(VALID), .OK(OK), .NG(NG), .BCD_ERR(BCD_ERR), .PRODUCT(PRODUCT)
   );

   always #5 CLK = ~CLK;

   // Drives one request and watches 25 cycles. It records the first VALID
   // cycle, the number of VALID pulses, the first cycle with BUSY low, and
   // whether OK/NG stayed unchanged before VALID. Cycle 1 is the cycle after
   // the accepting edge.
   task automatic judge(input logic [11:0] q, input logic [23:0] a,
                        output int vcyc, output int nvalid, output int busy_lo,
                        output bit held);
      logic ok0, ng0;
      ok0 = OK; ng0 = NG;
      QUESTION = q; ANSWER = a; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      // Inputs are scrambled after acceptance and must not affect the result.
      QUESTION = 12'h555; ANSWER = 24'h111111;
      vcyc = 0; nvalid = 0; busy_lo = 0; held = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         if (VALID) begin
            nvalid++;
            if (vcyc == 0) vcyc = c;
         end
         if (!BUSY && busy_lo == 0) busy_lo = c;
         if (vcyc == 0 && (OK !== ok0 || NG !== ng0)) held = 1'b0;
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
      checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", VALID); end
      checks++; if ({OK, NG, BCD_ERR} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {OK, NG, BCD_ERR}); end
      checks++; if (PRODUCT !== 21'd0) begin errors++; $display("FAIL reset_product got %0d exp 0", PRODUCT); end
      RST = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_basic();
      int v, n, b; bit h;
      judge(12'h012, 24'h020203, v, n, b, h);
      checks++; if (v != 17) begin errors++; $display("FAIL basic_latency got %0d exp 17", v); end
      checks++; if (n != 1) begin errors++; $display("FAIL basic_nvalid got %0d exp 1", n); end
      checks++; if (b != 18) begin errors++; $display("FAIL basic_busy_low got %0d exp 18", b); end
      checks++; if ({OK, NG} !== 2'b10) begin errors++; $display("FAIL basic_verdict got %b exp 10", {OK, NG}); end
      checks++; if (PRODUCT !== 21'd12) begin errors++; $display("FAIL basic_product got %0d exp 12", PRODUCT); end
      checks++; if (BCD_ERR !== 1'b0) begin errors++; $display("FAIL basic_bcd_err got %b exp 0", BCD_ERR); end
      judge(12'h105, 24'h030507, v, n, b, h);
      checks++; if ({OK, NG, PRODUCT} !== {2'b10, 21'd105}) begin errors++; $display("FAIL basic2 got ok=%b ng=%b p=%0d exp ok=1 ng=0 p=105", OK, NG, PRODUCT); end
   endtask

   task automatic test_mismatch();
      int v, n, b; bit h;
      logic exp_ok;
      judge(12'h012, 24'h020700, v, n, b, h);
      checks++; if (!h) begin errors++; $display("FAIL mismatch_prev_held got 0 exp 1"); end
      checks++; if ({OK, NG} !== 2'b01) begin errors++; $display("FAIL mismatch_verdict got %b exp 01", {OK, NG}); end
      checks++; if (PRODUCT !== 21'd14) begin errors++; $display("FAIL mismatch_product got %0d exp 14", PRODUCT); end
`ifdef JUDGE_PRIME_CHECK_EN
      exp_ok = 1'b0;
`else
      exp_ok = 1'b1;
`endif
      judge(12'h012, 24'h040300, v, n, b, h);
      checks++; if ({OK, NG} !== {exp_ok, ~exp_ok}) begin errors++; $display("FAIL nonprime_verdict got %b exp %b", {OK, NG}, {exp_ok, ~exp_ok}); end
      checks++; if (PRODUCT !== 21'd12) begin errors++; $display("FAIL nonprime_product got %0d exp 12", PRODUCT); end
   endtask

   task automatic test_zero_overflow();
      int v, n, b; bit h;
      judge(12'h999, 24'h000000, v, n, b, h);
      checks++; if ({OK, NG, PRODUCT} !== {2'b01, 21'd1}) begin errors++; $display("FAIL allzero got ok=%b ng=%b p=%0d exp ok=0 ng=1 p=1", OK, NG, PRODUCT); end
      judge(12'h970, 24'h999999, v, n, b, h);
      checks++; if ({OK, NG} !== 2'b01) begin errors++; $display("FAIL max_verdict got %b exp 01", {OK, NG}); end
      checks++; if (PRODUCT !== 21'd970299) begin errors++; $display("FAIL max_product got %0d exp 970299", PRODUCT); end
      checks++; if (v != 17) begin errors++; $display("FAIL max_latency got %0d exp 17", v); end
      judge(12'h000, 24'h000001, v, n, b, h);
      checks++; if ({OK, NG, PRODUCT} !== {2'b01, 21'd1}) begin errors++; $display("FAIL qzero got ok=%b ng=%b p=%0d exp ok=0 ng=1 p=1", OK, NG, PRODUCT); end
   endtask

   task automatic test_bcd_err();
      int v, n, b; bit h;
      judge(12'h012, 24'h0A0304, v, n, b, h);
      checks++; if (v != 17) begin errors++; $display("FAIL bcd_latency got %0d exp 17", v); end
      checks++; if ({OK, NG, BCD_ERR} !== 3'b011) begin errors++; $display("FAIL bcd_flags got %b exp 011", {OK, NG, BCD_ERR}); end
      // A bad nibble in the question also counts.
      judge(12'h01F, 24'h020203, v, n, b, h);
      checks++; if ({OK, NG, BCD_ERR} !== 3'b011) begin errors++; $display("FAIL bcdq_flags got %b exp 011", {OK, NG, BCD_ERR}); end
      judge(12'h012, 24'h020203, v, n, b, h);
      checks++; if ({OK, NG, BCD_ERR} !== 3'b100) begin errors++; $display("FAIL bcd_clear got %b exp 100", {OK, NG, BCD_ERR}); end
   endtask

   task automatic test_back_to_back();
      int v1 = 0, v2 = 0, n = 0;
      logic [20:0] p1 = '0, p2 = '0;
      logic busy18 = 1'b1;
      QUESTION = 12'h012; ANSWER = 24'h020203; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (VALID) begin
            n++;
            if (v1 == 0) begin v1 = c; p1 = PRODUCT; end
            else if (v2 == 0) begin v2 = c; p2 = PRODUCT; end
         end
         if (c == 18) busy18 = BUSY;
         if (c == 5 || c == 17) begin QUESTION = 12'h729; ANSWER = 24'h090909; START = 1'b1; end
         if (c == 18) begin QUESTION = 12'h105; ANSWER = 24'h030507; START = 1'b1; end
         @(posedge CLK); #1;
         START = 1'b0;
      end
      checks++; if (v1 != 17) begin errors++; $display("FAIL b2b_first_valid got %0d exp 17", v1); end
      checks++; if (p1 !== 21'd12) begin errors++; $display("FAIL b2b_first_product got %0d exp 12", p1); end
      checks++; if (busy18 !== 1'b0) begin errors++; $display("FAIL b2b_busy18 got %b exp 0", busy18); end
      checks++; if (v2 != 35) begin errors++; $display("FAIL b2b_second_valid got %0d exp 35", v2); end
      checks++; if (p2 !== 21'd105) begin errors++; $display("FAIL b2b_second_product got %0d exp 105", p2); end
      checks++; if (n != 2) begin errors++; $display("FAIL b2b_nvalid got %0d exp 2", n); end
   endtask

   task automatic test_reset_mid();
      int v, n, b; bit h;
      int nv = 0;
      QUESTION = 12'h012; ANSWER = 24'h020203; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (7) @(posedge CLK);
      #1;
      RST = 1'b1;
      #1;
      checks++; if ({BUSY, VALID, OK, NG, BCD_ERR} !== 5'b0 || PRODUCT !== 21'd0) begin
         errors++; $display("FAIL midreset_outputs got busy=%b v=%b ok=%b ng=%b e=%b p=%0d exp all 0", BUSY, VALID, OK, NG, BCD_ERR, PRODUCT); end
      @(posedge CLK); #1;
      RST = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (VALID) nv++;
         @(posedge CLK); #1;
      end
      checks++; if (nv != 0) begin errors++; $display("FAIL midreset_novalid got %0d exp 0", nv); end
      judge(12'h012, 24'h020203, v, n, b, h);
      checks++; if (v != 17 || {OK, NG} !== 2'b10) begin errors++; $display("FAIL midreset_rerun got v=%0d verdict=%b exp v=17 verdict=10", v, {OK, NG}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mismatch();
      test_zero_overflow();
      test_bcd_err();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
